osd_text_scanout: RTL and testbench

// Read-side counterpart of the OSD character buffer. Walks the COLS x ROWS text buffer in raster order

---
 rtl/osd_text_scanout.sv | 154 +++++++++++++++
 tb/tb_osd_text_scanout.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_text_scanout.sv
// OSD text scan-out: walks the character buffer in raster order, fetches glyph rows from the
// font ROM and serializes them into a 1-bit overlay pixel aligned with the delayed video timing.
module osd_text_scanout #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned FONT_H = 8,
  parameter int unsigned X0     = 0,
  parameter int unsigned Y0     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        osd_en,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  output logic        v_rd_en,
  output logic [15:0] v_rd_addr,
  input  logic [7:0]  v_rd_data,
  output logic        f_rd_en,
  output logic [11:0] f_rd_addr,
  input  logic [7:0]  f_rd_data,
  output logic        osd_pix,
  output logic        osd_active,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned POS_W   = 17;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned GL_W    = 4;
  localparam int unsigned FONT_SH = $clog2(FONT_H);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] X0_C    = CNT_W'(X0);
  localparam logic [CNT_W-1:0] Y0_C    = CNT_W'(Y0);
  localparam logic [CNT_W-1:0] GL_MASK = CNT_W'(FONT_H - 1);
  localparam logic [POS_W-1:0] X_LO    = POS_W'(X0);
  localparam logic [POS_W-1:0] X_HI    = POS_W'(X0 + 8 * COLS);
  localparam logic [POS_W-1:0] Y_LO    = POS_W'(Y0);
  localparam logic [POS_W-1:0] Y_HI    = POS_W'(Y0 + FONT_H * ROWS);

  // Side data that travels with each pixel through the fetch pipeline
  typedef struct packed {
    logic            win;
    logic [2:0]      xb;
    logic [GL_W-1:0] gl;
    logic            de;
    logic            hs;
    logic            vs;
  } pix_tag_t;

  logic [CNT_W-1:0]  px;
  logic [CNT_W-1:0]  ln;
  logic              de_q;
  logic              vs_q;
  logic              de_fall;
  logic              vs_rise;

  logic              win;
  logic [CNT_W-1:0]  dx;
  logic [CNT_W-1:0]  dy;
  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [ADDR_W-1:0] cell_addr;
  pix_tag_t          tag0;
  pix_tag_t          s1;
  pix_tag_t          s2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign de_fall = de_q & ~vid_de;
  assign vs_rise = vid_vs & ~vs_q;

  // Raster position counters; a VS rising edge overrides the line increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px   <= '0;
      ln   <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (pix_ce) begin
      de_q <= vid_de;
      vs_q <= vid_vs;
      if (vid_de) begin
        px <= sat_inc(px);
      end else if (de_fall) begin
        px <= '0;
      end
      if (vs_rise) begin
        ln <= '0;
      end else if (de_fall) begin
        ln <= sat_inc(ln);
      end
    end
  end

  // Stage 0: window test and cell address for the pixel currently presented
  always_comb begin
    dx        = px - X0_C;
    dy        = ln - Y0_C;
    win       = vid_de
              & (POS_W'(px) >= X_LO) & (POS_W'(px) < X_HI)
              & (POS_W'(ln) >= Y_LO) & (POS_W'(ln) < Y_HI);
    col       = dx >> 3;
    row       = dy >> FONT_SH;
    cell_addr = ADDR_W'((32'(row) * 32'(COLS)) + 32'(col));
    tag0      = '0;
    tag0.win  = win;
    tag0.xb   = dx[2:0];
    tag0.gl   = GL_W'(dy & GL_MASK);
    tag0.de   = vid_de;
    tag0.hs   = vid_hs;
    tag0.vs   = vid_vs;
  end

  assign v_rd_en   = pix_ce;
  assign f_rd_en   = pix_ce;
  assign v_rd_addr = (rst_n && win) ? cell_addr : '0;
  // Stage 1: character code from the buffer selects the glyph row
  assign f_rd_addr = rst_n ? {v_rd_data, s1.gl} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (pix_ce) begin
      s1 <= tag0;
      s2 <= s1;
    end
  end

  // Stage 2: pick the glyph bit (bit 7 is the leftmost pixel) and emit aligned timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osd_pix    <= 1'b0;
      osd_active <= 1'b0;
      out_de     <= 1'b0;
      out_hs     <= 1'b0;
      out_vs     <= 1'b0;
    end else if (pix_ce) begin
      osd_pix    <= osd_en & s2.win & f_rd_data[~s2.xb];
      osd_active <= s2.win;
      out_de     <= s2.de;
      out_hs     <= s2.hs;
      out_vs     <= s2.vs;
    end
  end

endmodule

// File: tb/tb_osd_text_scanout.sv
// Scoreboard bench for osd_text_scanout: stimulus pushes expected pixels from a frame-position
// model of buffer and font; a monitor pops one entry per pixel-clock-enable edge and compares.
module tb_osd_text_scanout;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int FONT_H = 8;
  localparam int X0     = 16;
  localparam int Y0     = 8;

  logic        clk;
  logic        rst_n;
  logic        pix_ce;
  logic        osd_en;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;
  logic        v_rd_en;
  logic [15:0] v_rd_addr;
  logic [7:0]  v_rd_data;
  logic        f_rd_en;
  logic [11:0] f_rd_addr;
  logic [7:0]  f_rd_data;
  logic        osd_pix;
  logic        osd_active;
  logic        out_de;
  logic        out_hs;
  logic        out_vs;

  osd_text_scanout #(
    .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .X0(X0), .Y0(Y0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .osd_en(osd_en),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .v_rd_en(v_rd_en), .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data),
    .f_rd_en(f_rd_en), .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data),
    .osd_pix(osd_pix), .osd_active(osd_active),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] vbuf [0:65535];
  logic [7:0] font [0:4095];

  // Synchronous memories: data one clock after enable, held while enable is low
  always @(posedge clk) begin
    if (v_rd_en) v_rd_data <= vbuf[v_rd_addr];
    if (f_rd_en) f_rd_data <= font[f_rd_addr];
  end

  typedef struct {
    logic pix;
    logic act;
    logic de;
    logic hs;
    logic vs;
    int   x;
    int   y;
    int   tag;
  } exp_t;

  exp_t       sbq[$];
  int         errors;
  int         checks;
  int         ce_gap;
  int         cap_sel;
  logic [7:0] cap0;
  logic [7:0] cap41a;
  logic [7:0] cap41b;
  int         act_cnt;
  int         pix_cnt;
  int         rst_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic in_win(input logic de, input int x, input int y);
    return de && (x >= X0) && (x < X0 + 8 * COLS) && (y >= Y0) && (y < Y0 + FONT_H * ROWS);
  endfunction

  function automatic int exp_addr(input logic de, input int x, input int y);
    if (!in_win(de, x, y)) return 0;
    return ((y - Y0) / FONT_H) * COLS + (x - X0) / 8;
  endfunction

  function automatic exp_t model(input logic de, input logic hs, input logic vs,
                                 input int x, input int y);
    exp_t       m;
    logic [7:0] ch;
    logic [7:0] g;
    m.pix = 1'b0;
    m.act = in_win(de, x, y);
    m.de  = de;
    m.hs  = hs;
    m.vs  = vs;
    m.x   = x;
    m.y   = y;
    m.tag = cap_sel;
    if (m.act) begin
      ch    = vbuf[exp_addr(de, x, y)];
      g     = font[{ch, 4'((y - Y0) % FONT_H)}];
      m.pix = osd_en & g[7 - ((x - X0) % 8)];
    end
    return m;
  endfunction

  // One pixel-clock-enable sample at frame position (x, y)
  task automatic sample(input logic de, input logic hs, input logic vs, input int x, input int y);
    repeat (ce_gap) begin
      @(negedge clk);
      pix_ce = 1'b0;
    end
    @(negedge clk);
    pix_ce = 1'b1;
    vid_de = de;
    vid_hs = hs;
    vid_vs = vs;
    sbq.push_back(model(de, hs, vs, x, y));
    #1;
    chk("v_rd_addr", 32'(v_rd_addr), 32'(exp_addr(de, x, y)));
    if (de && x == X0 && y == Y0)
      chk("addr_first_cell", 32'(v_rd_addr), 32'd0);
    if (de && x == X0 + 8 * 39 && y == Y0 + 8 * 29)
      chk("addr_last_cell", 32'(v_rd_addr), 32'd1199);
  endtask

  task automatic end_line(input int y);
    sample(1'b0, 1'b0, 1'b0, 0, y);
    sample(1'b0, 1'b1, 1'b0, 0, y);
    sample(1'b0, 1'b1, 1'b0, 0, y);
    sample(1'b0, 1'b0, 1'b0, 0, y);
  endtask

  task automatic line(input int n, input int y);
    for (int i = 0; i < n; i++) sample(1'b1, 1'b0, 1'b0, i, y);
    end_line(y);
  endtask

  task automatic vsync();
    sample(1'b0, 1'b0, 1'b1, 0, 0);
    sample(1'b0, 1'b0, 1'b1, 0, 0);
    sample(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_ce = 1'b0;
    rst_n  = 1'b0;
    sbq.delete();
    #1;
    chk("reset_outs", 32'({osd_pix, osd_active, out_de, out_hs, out_vs}), 32'd0);
    chk("reset_v_rd_addr", 32'(v_rd_addr), 32'd0);
    chk("reset_f_rd_addr", 32'(f_rd_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: each enabled edge retires one expected pixel; between enables outputs must hold
  logic       ce_at;
  logic       rst_at;
  logic [4:0] cur;
  logic [4:0] prev_o;
  exp_t       em;

  always @(posedge clk) begin
    ce_at  = pix_ce;
    rst_at = rst_n;
    #1;
    cur = {osd_pix, osd_active, out_de, out_hs, out_vs};
    if (rst_at) begin
      if (ce_at) begin
        if (sbq.size() >= 3) begin
          em = sbq.pop_front();
          chk("pixel_out", 32'(cur), 32'({em.pix, em.act, em.de, em.hs, em.vs}));
          if (em.tag == 1 && em.act && em.y == Y0 && em.x < X0 + 8)
            cap0[7 - (em.x - X0)] = osd_pix;
          if (em.act && em.y == Y0 + FONT_H && em.x >= X0 + 8 && em.x < X0 + 16) begin
            if (em.tag == 1) cap41a[7 - (em.x - X0 - 8)] = osd_pix;
            if (em.tag == 2) cap41b[7 - (em.x - X0 - 8)] = osd_pix;
          end
          if (em.tag == 3) begin
            act_cnt += int'(osd_active);
            pix_cnt += int'(osd_pix);
          end
          if (em.tag == 5) rst_cnt += int'(osd_pix) + int'(osd_active);
        end else begin
          chk("pipeline_fill", 32'(cur), 32'd0);
        end
      end else begin
        chk("hold_no_ce", 32'(cur), 32'(prev_o));
      end
    end
    prev_o = cur;
  end

  initial begin
    errors    = 0;
    checks    = 0;
    ce_gap    = 0;
    cap_sel   = 0;
    cap0      = '0;
    cap41a    = '0;
    cap41b    = '0;
    act_cnt   = 0;
    pix_cnt   = 0;
    rst_cnt   = 0;
    prev_o    = '0;
    rst_n     = 1'b0;
    pix_ce    = 1'b0;
    osd_en    = 1'b1;
    vid_de    = 1'b0;
    vid_hs    = 1'b0;
    vid_vs    = 1'b0;
    v_rd_data = '0;
    f_rd_data = '0;
    for (int i = 0; i < 65536; i++) vbuf[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4096; i++)  font[i] = 8'($urandom);
    vbuf[0]       = 8'h41;
    vbuf[41]      = 8'h41;
    font[12'h410] = 8'h18;
    font[12'h420] = 8'h3C;

    // Reset state, then release in the middle of an active line
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 32'({osd_pix, osd_active, out_de, out_hs, out_vs}), 32'd0);
    chk("reset_v_rd_addr", 32'(v_rd_addr), 32'd0);
    chk("reset_f_rd_addr", 32'(f_rd_addr), 32'd0);
    vid_de = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) sample(1'b1, 1'b0, 1'b0, i, 0);
    end_line(0);
    line(40, 1);

    // Full-height frame; cell 41 rewritten after its row has been scanned
    vsync();
    cap_sel = 1;
    for (int y = 0; y < 248; y++) begin
      line((y == 240) ? 336 : 40, y);
      if (y == 30) vbuf[41] = 8'h42;
    end

    // Next frame shows the new glyph in cell 41
    vsync();
    cap_sel = 2;
    for (int y = 0; y < 24; y++) line(40, y);

    // Overlay disabled; the last line's DE fall coincides with the VS rise
    vsync();
    cap_sel = 3;
    osd_en  = 1'b0;
    for (int y = 0; y < 11; y++) line(40, y);
    for (int i = 0; i < 40; i++) sample(1'b1, 1'b0, 1'b0, i, 11);
    sample(1'b0, 1'b0, 1'b1, 0, 11);
    sample(1'b0, 1'b0, 1'b1, 0, 0);
    sample(1'b0, 1'b0, 1'b0, 0, 0);
    cap_sel = 4;
    osd_en  = 1'b1;
    for (int y = 0; y < 10; y++) line(40, y);

    // Sparse pixel enable with fresh random font contents
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    font[12'h410] = 8'h18;
    font[12'h420] = 8'h3C;
    ce_gap = 3;
    vsync();
    for (int y = 0; y < 20; y++) line(40, y);
    ce_gap = 0;

    // Reset in the middle of a window line; line count restarts from zero
    vsync();
    for (int y = 0; y < 12; y++) line(40, y);
    for (int i = 0; i < 20; i++) sample(1'b1, 1'b0, 1'b0, i, 12);
    do_reset();
    cap_sel = 5;
    for (int i = 0; i < 20; i++) sample(1'b1, 1'b0, 1'b0, i, 0);
    end_line(0);
    line(40, 1);
    line(40, 2);
    cap_sel = 6;
    vsync();
    for (int y = 0; y < 10; y++) line(40, y);
    repeat (4) sample(1'b0, 1'b0, 1'b0, 0, 0);

    chk("cell0_glyph_line0", 32'(cap0), 32'h18);
    chk("cell41_first_frame", 32'(cap41a), 32'h18);
    chk("cell41_next_frame", 32'(cap41b), 32'h3C);
    chk("osd_off_active_count", 32'(act_cnt), 32'd96);
    chk("osd_off_pix_count", 32'(pix_cnt), 32'd0);
    chk("post_reset_quiet", 32'(rst_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
